// File: rtl/step_pulse_monitor.sv
// Step/dir receive monitor: synchronises step_in/dir_in, tracks signed position, measures step period,
// and flags a stalled pulse train. Optional glitch filter on the synced step: define STEP_FILTER_EN.
module step_pulse_monitor #(
   parameter int unsigned SIZE        = 16,
   parameter int unsigned POS_W       = 32,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned FILT_LEN    = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic             step_in,
   input  logic             dir_in,
   input  logic             clr_pos,
   input  logic [SIZE:0]    timeout_lim,
   output logic [POS_W-1:0] position,
   output logic [SIZE:0]    period,
   output logic             period_valid,
   output logic             step_det,
   output logic             timeout,
   output logic             overrun
);

   localparam int unsigned CW = SIZE + 1;
   localparam logic [CW-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      MEASURE = 2'd1,
      TIMEOUT = 2'd2
   } state_t;

   if (SYNC_STAGES < 2 || FILT_LEN < 1) begin : g_param_check
      $error("step_pulse_monitor: SYNC_STAGES must be >= 2 and FILT_LEN >= 1");
   end

   logic [SYNC_STAGES-1:0] step_sync;
   logic [SYNC_STAGES-1:0] dir_sync;
   logic                   step_lvl;
   logic                   dir_lvl;
   logic                   step_q;
   logic                   dir_q;
   logic                   step_prev;
   logic                   dir_det;
   logic                   edge_hit;
   logic [CW-1:0]          cnt;
   logic [POS_W-1:0]       pos_next;
   logic                   load_period;
   logic                   pv_next;
   state_t                 state_q;
   state_t                 state_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         step_sync <= '0;
         dir_sync  <= '0;
      end else begin
         step_sync[0] <= step_in;
         dir_sync[0]  <= dir_in;
         for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
            step_sync[i] <= step_sync[i-1];
            dir_sync[i]  <= dir_sync[i-1];
         end
      end
   end

   assign step_lvl = step_sync[SYNC_STAGES-1];
   assign dir_lvl  = dir_sync[SYNC_STAGES-1];

`ifdef STEP_FILTER_EN
   localparam int unsigned FCW = $clog2(FILT_LEN + 1);

   logic [FCW-1:0]      filt_cnt;
   logic                step_filt;
   logic [FILT_LEN-1:0] dir_dly;

   // Level only follows the synced input after FILT_LEN consecutive differing samples;
   // dir rides a matching delay line so it stays aligned with the filtered step.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         filt_cnt  <= '0;
         step_filt <= 1'b0;
         dir_dly   <= '0;
      end else begin
         if (step_lvl != step_filt) begin
            if (filt_cnt == FCW'(FILT_LEN - 1)) begin
               step_filt <= step_lvl;
               filt_cnt  <= '0;
            end else begin
               filt_cnt <= filt_cnt + 1'b1;
            end
         end else begin
            filt_cnt <= '0;
         end
         dir_dly[0] <= dir_lvl;
         for (int unsigned i = 1; i < FILT_LEN; i++) begin
            dir_dly[i] <= dir_dly[i-1];
         end
      end
   end

   assign step_q = step_filt;
   assign dir_q  = dir_dly[FILT_LEN-1];
`else
   assign step_q = step_lvl;
   assign dir_q  = dir_lvl;
`endif

   assign edge_hit = enable & step_q & ~step_prev;

   always_comb begin
      pos_next = clr_pos ? '0 : position;
      if (step_det) begin
         pos_next = dir_det ? pos_next + POS_W'(1) : pos_next - POS_W'(1);
      end
   end

   always_comb begin
      state_d     = state_q;
      load_period = 1'b0;
      pv_next     = 1'b0;
      if (!enable) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (edge_hit) state_d = MEASURE;
            end
            MEASURE: begin
               if (edge_hit) begin
                  load_period = 1'b1;
                  pv_next     = 1'b1;
               end else if (timeout_lim != '0 && cnt >= timeout_lim) begin
                  state_d = TIMEOUT;
               end
            end
            TIMEOUT: begin
               if (edge_hit) state_d = MEASURE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   assign timeout = (state_q == TIMEOUT);

   // Period/cnt are loaded on the same edge that raises step_det, so period_valid
   // coincides with the step_det that closes the interval.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         step_prev    <= 1'b0;
         step_det     <= 1'b0;
         dir_det      <= 1'b0;
         cnt          <= '0;
         position     <= '0;
         period       <= '0;
         period_valid <= 1'b0;
         overrun      <= 1'b0;
      end else begin
         state_q      <= state_d;
         step_prev    <= step_q;
         step_det     <= edge_hit;
         dir_det      <= dir_q;
         position     <= pos_next;
         period_valid <= pv_next;
         if (load_period) begin
            period  <= cnt;
            overrun <= (cnt == CNT_MAX);
         end
         if (edge_hit) begin
            cnt <= CW'(1);
         end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_step_pulse_monitor.sv
// Scoreboard bench for step_pulse_monitor: a default instance plus a SIZE=4 instance sharing stimulus.
module tb_step_pulse_monitor;

`ifdef STEP_FILTER_EN
   localparam int LAT = 6;
`else
   localparam int LAT = 3;
`endif

   logic        clk = 1'b0;
   logic        rst_n, enable, step_in, dir_in, clr_pos;
   logic [16:0] timeout_lim;
   logic [4:0]  timeout_lim_s;
   logic [31:0] position;
   logic [16:0] period;
   logic        period_valid, step_det, timeout, overrun;
   logic [31:0] s_position;
   logic [4:0]  s_period;
   logic        s_period_valid, s_step_det, s_timeout, s_overrun;

   always #5 clk = ~clk;

   step_pulse_monitor #(.SIZE(16), .POS_W(32), .SYNC_STAGES(2), .FILT_LEN(3)) u_dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .step_in(step_in), .dir_in(dir_in),
      .clr_pos(clr_pos), .timeout_lim(timeout_lim), .position(position), .period(period),
      .period_valid(period_valid), .step_det(step_det), .timeout(timeout), .overrun(overrun));

   step_pulse_monitor #(.SIZE(4), .POS_W(32), .SYNC_STAGES(2), .FILT_LEN(3)) u_small (
      .clk(clk), .rst_n(rst_n), .enable(enable), .step_in(step_in), .dir_in(dir_in),
      .clr_pos(clr_pos), .timeout_lim(timeout_lim_s), .position(s_position), .period(s_period),
      .period_valid(s_period_valid), .step_det(s_step_det), .timeout(s_timeout), .overrun(s_overrun));

   typedef struct {
      bit          seen;
      bit          extra;
      int          lat;
      bit          pv;
      bit          ovr;
      bit          to;
      logic [16:0] per;
      logic [31:0] pos;
      bit          s_ovr;
      logic [4:0]  s_per;
   } cap_t;

   typedef struct {
      bit          pv;
      bit          chk_per;
      logic [16:0] per;
      logic [31:0] pos;
   } exp_t;

   exp_t        sb[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] pos_m;

   // Expected outcome of the next step, derived from the stimulus only.
   task automatic push_exp(input bit pv, input bit chk, input logic [16:0] per, input bit d, input bit clr);
      exp_t e;
      if (clr) pos_m = '0;
      pos_m = d ? pos_m + 32'd1 : pos_m - 32'd1;
      e.pv = pv; e.chk_per = chk; e.per = per; e.pos = pos_m;
      sb.push_back(e);
   endtask

   // Called at a negedge: raises step_in now, holds it `width` cycles, returns `gap` negedges later.
   task automatic run_step(input bit d, input int width, input int gap, input bit clr_at_det, output cap_t c);
      bit pos_pending;
      c = '{default: 0};
      pos_pending = 0;
      dir_in  = d;
      step_in = 1'b1;
      for (int i = 1; i <= gap; i++) begin
         @(negedge clk);
         if (i == width) step_in = 1'b0;
         if (pos_pending) begin
            c.pos = position;
            pos_pending = 0;
            clr_pos = 1'b0;
         end
         if (step_det) begin
            if (c.seen) c.extra = 1;
            else begin
               c.seen = 1; c.lat = i; c.pv = period_valid; c.per = period; c.ovr = overrun;
               c.to = timeout; c.s_per = s_period; c.s_ovr = s_overrun;
               pos_pending = 1;
               if (clr_at_det) clr_pos = 1'b1;
            end
         end
      end
      step_in = 1'b0;
   endtask

   task automatic test_reset;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({position, period} !== 49'd0) begin
         n_fail++; $display("FAIL reset_pos_period: got %0h/%0h expected 0/0", position, period);
      end
      n_checks++;
      if ({period_valid, step_det, timeout, overrun} !== 4'b0) begin
         n_fail++; $display("FAIL reset_flags: got %b expected 0000", {period_valid, step_det, timeout, overrun});
      end
      rst_n = 1'b1;
      enable = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_period;
      cap_t c; exp_t e; int npv;
      npv = 0;
      for (int k = 1; k <= 10; k++) begin
         push_exp(k > 1, k > 1, 17'd100, 1'b1, 1'b0);
         run_step(1'b1, 5, 100, 1'b0, c);
         e = sb.pop_front();
         npv += int'(c.pv);
         n_checks++;
         if (!c.seen || c.extra || c.lat != LAT) begin
            n_fail++; $display("FAIL period_det[%0d]: seen=%0d extra=%0d lat=%0d expected 1/0/%0d", k, c.seen, c.extra, c.lat, LAT);
         end
         n_checks++;
         if (c.pv !== e.pv || (e.chk_per && c.per !== e.per)) begin
            n_fail++; $display("FAIL period_val[%0d]: got pv=%0d per=%0d expected pv=%0d per=%0d", k, c.pv, c.per, e.pv, e.per);
         end
         n_checks++;
         if (c.pos !== e.pos) begin
            n_fail++; $display("FAIL period_pos[%0d]: got %0h expected %0h", k, c.pos, e.pos);
         end
      end
      n_checks++;
      if (npv != 9 || position !== 32'd10) begin
         n_fail++; $display("FAIL period_totals: got pv_count=%0d pos=%0d expected 9/10", npv, position);
      end
   endtask

   task automatic test_direction;
      cap_t c; exp_t e;
      clr_pos = 1'b1;
      @(negedge clk);
      clr_pos = 1'b0;
      @(negedge clk);
      pos_m = '0;
      n_checks++;
      if (position !== 32'd0) begin
         n_fail++; $display("FAIL dir_clear: got %0h expected 0", position);
      end
      for (int k = 1; k <= 4; k++) begin
         push_exp(1'b1, k > 1, 17'd100, 1'b0, k == 4);
         run_step(1'b0, 5, 100, k == 4, c);
         e = sb.pop_front();
         n_checks++;
         if (!c.seen || c.pv !== e.pv || (e.chk_per && c.per !== e.per)) begin
            n_fail++; $display("FAIL dir_val[%0d]: got seen=%0d pv=%0d per=%0d expected 1/%0d/%0d", k, c.seen, c.pv, c.per, e.pv, e.per);
         end
         n_checks++;
         if (c.pos !== e.pos) begin
            n_fail++; $display("FAIL dir_pos[%0d]: got %0h expected %0h", k, c.pos, e.pos);
         end
      end
      n_checks++;
      if (position !== 32'hFFFF_FFFF) begin
         n_fail++; $display("FAIL dir_clr_coincident: got %0h expected ffffffff", position);
      end
   endtask

   task automatic test_timeout;
      cap_t c; exp_t e;
      timeout_lim = 17'd500;
      push_exp(1'b1, 1'b1, 17'd100, 1'b1, 1'b0);
      run_step(1'b1, 5, 100, 1'b0, c);
      e = sb.pop_front();
      n_checks++;
      if (!c.seen || c.pv !== e.pv || c.per !== e.per || c.pos !== e.pos) begin
         n_fail++; $display("FAIL to_pre: got pv=%0d per=%0d pos=%0h expected %0d/%0d/%0h", c.pv, c.per, c.pos, e.pv, e.per, e.pos);
      end
      repeat (500 - 1 - (100 - LAT)) @(negedge clk);
      n_checks++;
      if (timeout !== 1'b0) begin
         n_fail++; $display("FAIL to_early: got %0b expected 0", timeout);
      end
      @(negedge clk);
      n_checks++;
      if (timeout !== 1'b1) begin
         n_fail++; $display("FAIL to_assert: got %0b expected 1", timeout);
      end
      push_exp(1'b0, 1'b0, 17'd0, 1'b1, 1'b0);
      run_step(1'b1, 5, 200, 1'b0, c);
      e = sb.pop_front();
      n_checks++;
      if (!c.seen || c.pv !== 1'b0 || c.to !== 1'b0 || c.pos !== e.pos) begin
         n_fail++; $display("FAIL to_exit: got seen=%0d pv=%0d to=%0d pos=%0h expected 1/0/0/%0h", c.seen, c.pv, c.to, c.pos, e.pos);
      end
      push_exp(1'b1, 1'b1, 17'd200, 1'b1, 1'b0);
      run_step(1'b1, 5, 100, 1'b0, c);
      e = sb.pop_front();
      n_checks++;
      if (c.pv !== e.pv || c.per !== e.per || c.pos !== e.pos) begin
         n_fail++; $display("FAIL to_after: got pv=%0d per=%0d pos=%0h expected %0d/%0d/%0h", c.pv, c.per, c.pos, e.pv, e.per, e.pos);
      end
      timeout_lim = '0;
   endtask

   task automatic test_overrun;
      cap_t c; exp_t e;
      push_exp(1'b1, 1'b1, 17'd100, 1'b1, 1'b0);
      run_step(1'b1, 5, 40, 1'b0, c);
      e = sb.pop_front();
      push_exp(1'b1, 1'b1, 17'd40, 1'b1, 1'b0);
      run_step(1'b1, 5, 10, 1'b0, c);
      e = sb.pop_front();
      n_checks++;
      if (c.s_per !== 5'd31 || c.s_ovr !== 1'b1) begin
         n_fail++; $display("FAIL ovr_sat: got per=%0d ovr=%0d expected 31/1", c.s_per, c.s_ovr);
      end
      n_checks++;
      if (c.per !== e.per || c.ovr !== 1'b0 || c.pos !== e.pos) begin
         n_fail++; $display("FAIL ovr_wide: got per=%0d ovr=%0d pos=%0h expected %0d/0/%0h", c.per, c.ovr, c.pos, e.per, e.pos);
      end
      push_exp(1'b1, 1'b1, 17'd10, 1'b1, 1'b0);
      run_step(1'b1, 5, 100, 1'b0, c);
      e = sb.pop_front();
      n_checks++;
      if (c.s_per !== 5'd10 || c.s_ovr !== 1'b0 || c.per !== e.per) begin
         n_fail++; $display("FAIL ovr_clear: got sper=%0d sovr=%0d per=%0d expected 10/0/%0d", c.s_per, c.s_ovr, c.per, e.per);
      end
   endtask

   task automatic test_enable;
      cap_t c; exp_t e;
      enable = 1'b0;
      run_step(1'b1, 5, 30, 1'b0, c);
      n_checks++;
      if (c.seen || timeout !== 1'b0 || position !== pos_m) begin
         n_fail++; $display("FAIL en_off: got seen=%0d to=%0d pos=%0h expected 0/0/%0h", c.seen, timeout, position, pos_m);
      end
      enable = 1'b1;
      push_exp(1'b0, 1'b0, 17'd0, 1'b1, 1'b0);
      run_step(1'b1, 5, 100, 1'b0, c);
      e = sb.pop_front();
      n_checks++;
      if (!c.seen || c.pv !== e.pv || c.pos !== e.pos) begin
         n_fail++; $display("FAIL en_first: got seen=%0d pv=%0d pos=%0h expected 1/0/%0h", c.seen, c.pv, c.pos, e.pos);
      end
      push_exp(1'b1, 1'b1, 17'd100, 1'b1, 1'b0);
      run_step(1'b1, 5, 50, 1'b0, c);
      e = sb.pop_front();
      n_checks++;
      if (c.pv !== e.pv || c.per !== e.per || c.pos !== e.pos) begin
         n_fail++; $display("FAIL en_second: got pv=%0d per=%0d pos=%0h expected 1/%0d/%0h", c.pv, c.per, c.pos, e.per, e.pos);
      end
   endtask

   task automatic test_reset_mid;
      cap_t c; exp_t e;
      step_in = 1'b1;
      repeat (LAT) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({position, period} !== 49'd0 || {period_valid, step_det, timeout, overrun} !== 4'b0) begin
         n_fail++; $display("FAIL mid_reset: got pos=%0h per=%0h flags=%b expected 0/0/0000", position, period,
                            {period_valid, step_det, timeout, overrun});
      end
      @(negedge clk);
      step_in = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      pos_m = '0;
      push_exp(1'b0, 1'b0, 17'd0, 1'b1, 1'b0);
      run_step(1'b1, 5, 60, 1'b0, c);
      e = sb.pop_front();
      n_checks++;
      if (!c.seen || c.pv !== e.pv || c.pos !== e.pos) begin
         n_fail++; $display("FAIL mid_first: got seen=%0d pv=%0d pos=%0h expected 1/0/%0h", c.seen, c.pv, c.pos, e.pos);
      end
      push_exp(1'b1, 1'b1, 17'd60, 1'b1, 1'b0);
      run_step(1'b1, 5, 60, 1'b0, c);
      e = sb.pop_front();
      n_checks++;
      if (c.pv !== e.pv || c.per !== e.per || c.pos !== e.pos) begin
         n_fail++; $display("FAIL mid_second: got pv=%0d per=%0d pos=%0h expected 1/%0d/%0h", c.pv, c.per, c.pos, e.per, e.pos);
      end
   endtask

   task automatic test_glitch;
      cap_t c; bit exp_seen;
`ifdef STEP_FILTER_EN
      exp_seen = 1'b0;
`else
      exp_seen = 1'b1;
`endif
      run_step(1'b1, 2, 30, 1'b0, c);
      if (exp_seen) pos_m = pos_m + 32'd1;
      n_checks++;
      if (c.seen !== exp_seen || c.extra || position !== pos_m) begin
         n_fail++; $display("FAIL glitch: got seen=%0d extra=%0d pos=%0h expected %0d/0/%0h", c.seen, c.extra, position, exp_seen, pos_m);
      end
      run_step(1'b1, 5, 30, 1'b0, c);
      pos_m = pos_m + 32'd1;
      n_checks++;
      if (!c.seen || c.extra || c.lat != LAT || c.pos !== pos_m) begin
         n_fail++; $display("FAIL long_pulse: got seen=%0d extra=%0d lat=%0d pos=%0h expected 1/0/%0d/%0h", c.seen, c.extra, c.lat, c.pos, LAT, pos_m);
      end
   endtask

   initial begin
      rst_n = 1'b0; enable = 1'b0; step_in = 1'b0; dir_in = 1'b0; clr_pos = 1'b0;
      timeout_lim = '0; timeout_lim_s = '0; pos_m = '0;
      test_reset;
      test_period;
      test_direction;
      test_timeout;
      test_overrun;
      test_enable;
      test_reset_mid;
      test_glitch;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
